// File: rtl/squeeze_bias_relu_pkg.sv
// Shared layer package: default layer geometry, bias ROM word type,
// and the activation saturation constant.
package squeeze_bias_relu_pkg;

  localparam int NUM_CH_DEF     = 16;
  localparam int ACC_W_DEF      = 32;
  localparam int OUT_W_DEF      = 16;
  localparam int FRAC_SHIFT_DEF = 8;

  localparam int BIAS_W     = 32;
  localparam int BIAS_ROM_W = 33;

  typedef logic [BIAS_ROM_W-1:0] bias_word_t;

  function automatic longint sat_max(input int ow);
    return (longint'(1) << (ow - 1)) - 1;
  endfunction

  localparam longint SAT_MAX_DEF = sat_max(OUT_W_DEF);

endpackage

// File: rtl/relu_sat.sv
// Combinational fixed-point rescale, ReLU and positive saturation.
// Shared between squeeze and expand layers.
module relu_sat
  import squeeze_bias_relu_pkg::*;
#(
  parameter int     SUM_W      = ACC_W_DEF + 2,
  parameter int     OUT_W      = OUT_W_DEF,
  parameter int     FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter longint SAT_MAX    = SAT_MAX_DEF
) (
  input  logic signed [SUM_W-1:0] sum_i,
  output logic        [OUT_W-1:0] act_o,
  output logic                    sat_o
);

  localparam logic [SUM_W-1:0] MAX_W = SUM_W'(SAT_MAX);

  logic signed [SUM_W-1:0] shifted;

  assign shifted = sum_i >>> FRAC_SHIFT;

  always_comb begin
    act_o = '0;
    sat_o = 1'b0;
    if (!sum_i[SUM_W-1]) begin
      if ($unsigned(shifted) > MAX_W) begin
        act_o = OUT_W'(SAT_MAX);
        sat_o = 1'b1;
      end else begin
        act_o = shifted[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/squeeze_bias_relu.sv
// Two-stage bias-add / ReLU / saturate pipeline for squeeze-layer
// accumulators, one channel per beat, valid/ready on both sides.
module squeeze_bias_relu
  import squeeze_bias_relu_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  bias_word_t                bias_mem [NUM_CH],
  input  logic                      soft_clr,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  input  logic [ACC_W-1:0]          acc_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      sat_flag
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SUM_W = ACC_W + 2;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]         ch_q, ch_d;
  logic                    s1_valid_q;
  logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [CH_W-1:0]         s1_ch_q;
  logic                    s2_valid_q;
  logic [OUT_W-1:0]        out_data_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_last_q;
  logic                    sat_q;

  logic             adv1, adv2, accept;
  logic [OUT_W-1:0] act;
  logic             act_sat;
  logic             unused_bias;

  assign adv2      = !s2_valid_q || out_ready;
  assign adv1      = !s1_valid_q || adv2;
  assign acc_ready = adv1 && !soft_clr;
  assign accept    = acc_valid && acc_ready;

  assign ch_d = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;

  assign s1_sum_d = SUM_W'($signed(acc_data))
                  + SUM_W'($signed(bias_mem[ch_q][BIAS_W-1:0]));

  // ROM flag bit carries no meaning for this layer
  always_comb begin
    unused_bias = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      unused_bias = unused_bias ^ bias_mem[i][BIAS_ROM_W-1];
  end

  relu_sat #(
    .SUM_W     (SUM_W),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT),
    .SAT_MAX   (sat_max(OUT_W))
  ) u_relu_sat (
    .sum_i(s1_sum_q),
    .act_o(act),
    .sat_o(act_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_ch_q    <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
      sat_q      <= 1'b0;
    end else if (soft_clr) begin
      ch_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      if (accept)
        ch_q <= ch_d;
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_sum_q <= s1_sum_d;
          s1_ch_q  <= ch_q;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_data_q <= act;
          out_ch_q   <= s1_ch_q;
          out_last_q <= (s1_ch_q == LAST_CH);
          if (act_sat)
            sat_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign sat_flag  = sat_q;

endmodule

// File: doc/squeeze_bias_relu.md
SQUEEZE_BIAS_RELU -- requirements
Module: squeeze_bias_relu

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: output channels per pixel, one accumulator per channel.
REQ-002 SHALL have parameter ACC_W, default 32: signed accumulator width.
REQ-003 SHALL have parameter OUT_W, default 16: activation output width.
REQ-004 SHALL have parameter FRAC_SHIFT, default 8: arithmetic right shift applied after bias add.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port bias_mem, input, 33 x NUM_CH unpacked: per-channel bias from the layer bias ROM; bits [31:0] are the signed value, bit 32 is ignored.
REQ-009 SHALL have port soft_clr, input, 1: synchronous flush of the pipeline and channel counter.
REQ-010 SHALL have port acc_valid, input, 1: acc_data is valid.
REQ-011 SHALL have port acc_ready, output, 1: the block accepts acc_data this cycle.
REQ-012 SHALL have port acc_data, input, ACC_W: signed MAC sum for the current channel.
REQ-013 SHALL have port out_valid, output, 1: out_data is valid.
REQ-014 SHALL have port out_ready, input, 1: the downstream stage accepts out_data.
REQ-015 SHALL have port out_data, output, OUT_W: ReLU'd, scaled, saturated activation.
REQ-016 SHALL have port out_ch, output, clog2(NUM_CH): channel index of out_data.
REQ-017 SHALL have port out_last, output, 1: out_data is the last channel (NUM_CH-1) of a pixel.
REQ-018 SHALL have port sat_flag, output, 1: sticky flag, set when any output saturated.

Function
REQ-019 The channel counter SHALL increment on each accepted input (acc_valid && acc_ready), wrapping from NUM_CH-1 to 0.
REQ-020 Stage 1 SHALL register sum = sext(acc_data, ACC_W+2) + sext(bias_mem[ch][31:0], ACC_W+2), together with the channel index.
REQ-021 Stage 2 SHALL register: 0 if sum < 0; otherwise sum >>> FRAC_SHIFT, truncated (no rounding), saturated to 2^(OUT_W-1)-1.
REQ-022 Latency SHALL be exactly 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-023 Each stage SHALL advance when it is empty or the stage after it advances; acc_ready SHALL equal stage-1 advance && !soft_clr.
REQ-024 With acc_valid held and out_ready high, throughput SHALL be one result per cycle with no bubbles.
REQ-025 While out_valid && !out_ready, out_data, out_ch and out_last SHALL remain stable.
REQ-026 out_last SHALL be high exactly when out_ch == NUM_CH-1.
REQ-027 soft_clr SHALL, on the next edge, zero the channel counter, invalidate both stages and not accept input, including when acc_valid is high in the same cycle.
REQ-028 sat_flag SHALL set in the cycle a saturated value is loaded into stage 2, and SHALL clear only on rst or soft_clr.

Reset
REQ-029 rst SHALL asynchronously clear the channel counter, both stage valids, out_data, out_ch, out_last and sat_flag to 0; acc_ready SHALL be 1 in the first cycle after reset.
REQ-030 If rst asserts mid-pixel, the partial pixel SHALL be discarded and the next accepted input SHALL be channel 0.

Structure
REQ-031 NUM_CH, ACC_W, OUT_W, FRAC_SHIFT defaults and the saturation constant SHALL live in the shared layer package, next to the bias ROM typedefs.
REQ-032 The scale/ReLU/saturate function SHALL be one sub-module, relu_sat, which is combinational and reused by the expand layers.

Verification
REQ-033 bias[1]=845, channel 1 acc=0 -> out_data=3, out_ch=1, 2 cycles after acceptance.
REQ-034 bias[3]=-480, channel 3 acc=100 -> sum -380 -> out_data=0, sat_flag stays 0.
REQ-035 bias[0]=0, channel 0 acc=0x7FFFFFFF -> out_data=32767, sat_flag=1 until soft_clr.
REQ-036 Stream of 32 inputs with out_ready=1 -> 32 consecutive outputs with out_ch 0..15,0..15 and out_last on the 16th and 32nd.
REQ-037 out_ready held low for 5 cycles mid-stream -> acc_ready drops once both stages are full, there is no loss or duplication, and out_data is stable.
REQ-038 soft_clr asserted with acc_valid after 7 inputs -> the input is not accepted, out_valid=0 next cycle, and the next accepted input is channel 0.
